// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one synchronous memory port between instruction fetch and
//            the LSU; a tag pipeline routes read responses to their owner.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    input  logic                    if_flush,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    busy
);

    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0]             r_starve;
    logic                   r_iss_rd;
    logic                   r_iss_fetch;
    logic [MEM_LATENCY-1:0] r_tag_vld;
    logic [MEM_LATENCY-1:0] r_tag_fetch;
    logic                   w_fetch_win;
    logic                   w_data_win;
    logic                   w_issue_rd;

    // Data normally wins; a starved fetch or a lone fetch takes the port.
    assign w_fetch_win = rst && if_req && (!d_req || (r_starve == c_STARVE_MAX));
    assign w_data_win  = rst && d_req && !w_fetch_win;
    assign if_gnt      = w_fetch_win;
    assign d_gnt       = w_data_win;
    assign w_issue_rd  = (w_fetch_win && !if_flush) || (w_data_win && !d_we);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (if_req && !w_fetch_win) begin
            if (r_starve != c_STARVE_MAX) begin
                r_starve <= r_starve + 4'd1;
            end
        end else begin
            r_starve <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
            r_iss_rd    <= 1'b0;
            r_iss_fetch <= 1'b0;
        end else begin
            mem_en      <= w_fetch_win || w_data_win;
            r_iss_rd    <= w_issue_rd;
            r_iss_fetch <= w_fetch_win;
            if (w_fetch_win) begin
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                mem_be    <= '1;
            end else if (w_data_win) begin
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_be    <= d_be;
            end
        end
    end

    // The issue register is the entry point; stage MEM_LATENCY-1 lines up with mem_rdata.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tag_vld   <= '0;
            r_tag_fetch <= '0;
        end else begin
            r_tag_vld[0]   <= r_iss_rd && !(if_flush && r_iss_fetch);
            r_tag_fetch[0] <= r_iss_fetch;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                r_tag_vld[i]   <= r_tag_vld[i-1] && !(if_flush && r_tag_fetch[i-1]);
                r_tag_fetch[i] <= r_tag_fetch[i-1];
            end
        end
    end

    assign if_rvalid = r_tag_vld[MEM_LATENCY-1] && r_tag_fetch[MEM_LATENCY-1] && !if_flush;
    assign d_rvalid  = r_tag_vld[MEM_LATENCY-1] && !r_tag_fetch[MEM_LATENCY-1];
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign busy      = mem_en || (|r_tag_vld);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Two arbiters (MEM_LATENCY 1 and 3) on shared stimulus, checked
//            against a queue-based response model.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int SL = 4;
    localparam int VW = 8 + AW + BW + DW;
    localparam int CT = VW - 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, if_req, if_flush, d_req, d_we;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic [BW-1:0] d_be;

    logic [1:0]    if_gnt_w, d_gnt_w, if_rvalid_w, d_rvalid_w, mem_en_w, mem_we_w, busy_w;
    logic [DW-1:0] if_rdata_w [2];
    logic [DW-1:0] d_rdata_w [2];
    logic [DW-1:0] mem_wdata_w [2];
    logic [AW-1:0] mem_addr_w [2];
    logic [BW-1:0] mem_be_w [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(
            .ADDR_WIDTH  (AW),
            .DATA_WIDTH  (DW),
            .MEM_LATENCY ((g == 0) ? 1 : 3),
            .STARVE_LIMIT(SL)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .if_req   (if_req),
            .if_addr  (if_addr),
            .if_flush (if_flush),
            .if_gnt   (if_gnt_w[g]),
            .if_rvalid(if_rvalid_w[g]),
            .if_rdata (if_rdata_w[g]),
            .d_req    (d_req),
            .d_we     (d_we),
            .d_addr   (d_addr),
            .d_wdata  (d_wdata),
            .d_be     (d_be),
            .d_gnt    (d_gnt_w[g]),
            .d_rvalid (d_rvalid_w[g]),
            .d_rdata  (d_rdata_w[g]),
            .mem_en   (mem_en_w[g]),
            .mem_we   (mem_we_w[g]),
            .mem_addr (mem_addr_w[g]),
            .mem_wdata(mem_wdata_w[g]),
            .mem_be   (mem_be_w[g]),
            .mem_rdata(mem_rdata),
            .busy     (busy_w[g])
        );
    end

    // Model: each outstanding read is a {dut, due cycle, owner, valid} record.
    typedef struct {
        int k;
        int due;
        bit fetch;
        bit vld;
    } ent_t;

    ent_t          rq[$];
    int            cyc = 0;
    int            m_starve = 0;
    bit            m_en = 0, m_we = 0, m_wk = 1;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [BW-1:0] m_be = '0;
    bit            e_ig = 0, e_dg = 0;
    bit [1:0]      e_irv, e_drv, e_busy;
    logic [VW-1:0] x_all [2];
    logic [VW-1:0] o_all [2];
    int            n_pass = 0, n_total = 0;

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic idle_inputs();
        if_req   = 1'b0;
        if_flush = 1'b0;
        d_req    = 1'b0;
        d_we     = 1'b0;
    endtask

    // One clock: snapshot expected and observed values at negedge, then advance the model.
    task automatic step();
        ent_t nq[$];
        ent_t e;
        mem_rdata = $urandom;
        @(negedge clk);
        e_ig   = rst && if_req && (!d_req || (m_starve == SL));
        e_dg   = rst && d_req && !e_ig;
        e_irv  = '0;
        e_drv  = '0;
        e_busy = {m_en, m_en};
        foreach (rq[j]) begin
            if (rq[j].vld) begin
                if (rq[j].due == cyc) begin
                    if (rq[j].fetch) e_irv[rq[j].k] = !if_flush;
                    else             e_drv[rq[j].k] = 1'b1;
                end
                if (rq[j].due < cyc + lat_of(rq[j].k)) e_busy[rq[j].k] = 1'b1;
            end
        end
        for (int k = 0; k < 2; k++) begin
            x_all[k] = {e_ig, e_dg, m_en, m_we, e_irv[k], e_drv[k], e_busy[k], 1'b1,
                        m_addr, m_be, (m_wk ? m_wdata : {DW{1'b0}})};
            o_all[k] = {if_gnt_w[k], d_gnt_w[k], mem_en_w[k], mem_we_w[k], if_rvalid_w[k],
                        d_rvalid_w[k], busy_w[k],
                        ((if_rdata_w[k] === mem_rdata) && (d_rdata_w[k] === mem_rdata)),
                        mem_addr_w[k], mem_be_w[k], (m_wk ? mem_wdata_w[k] : {DW{1'b0}})};
        end
        @(posedge clk);
        if (!rst) begin
            m_en = 0; m_we = 0; m_wk = 1; m_starve = 0;
            m_addr = '0; m_wdata = '0; m_be = '0;
            rq.delete();
        end else begin
            foreach (rq[j]) begin
                if (rq[j].due > cyc) begin
                    e = rq[j];
                    if (if_flush && e.fetch) e.vld = 0;
                    nq.push_back(e);
                end
            end
            rq = nq;
            if (e_ig || (e_dg && !d_we)) begin
                for (int k = 0; k < 2; k++) begin
                    e.k = k; e.due = cyc + 1 + lat_of(k); e.fetch = e_ig; e.vld = !(e_ig && if_flush);
                    rq.push_back(e);
                end
            end
            m_en = e_ig || e_dg;
            if (e_ig) begin
                m_we = 0; m_addr = if_addr; m_be = '1; m_wk = 0;
            end else if (e_dg) begin
                m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_be = d_be; m_wk = 1;
            end
            m_starve = (if_req && !e_ig) ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (o_all[k] !== x_all[k]) $display("FAIL reset dut%0d cyc%0d got %h exp %h", k, cyc - 1, o_all[k], x_all[k]);
                else n_pass++;
            end
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_single_fetch();
        if_req = 1'b1; if_addr = 32'h10;
        for (int i = 0; i < 5; i++) begin
            step();
            if_req = 1'b0;
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (o_all[k] !== x_all[k]) $display("FAIL single_fetch dut%0d cyc%0d got %h exp %h", k, cyc - 1, o_all[k], x_all[k]);
                else n_pass++;
            end
            if (i == 1) begin
                n_total++;
                if (o_all[0][CT+5] !== 1'b1 || o_all[0][DW+BW +: AW] !== 32'h10 || o_all[0][DW +: BW] !== 4'hF || o_all[0][CT+1] !== 1'b1)
                    $display("FAIL single_fetch_issue got en=%b addr=%h be=%h busy=%b exp en=1 addr=00000010 be=f busy=1",
                             o_all[0][CT+5], o_all[0][DW+BW +: AW], o_all[0][DW +: BW], o_all[0][CT+1]);
                else n_pass++;
            end
            if (i == 2) begin
                n_total++;
                if (o_all[0][CT+3] !== 1'b1 || o_all[0][CT+1] !== 1'b1)
                    $display("FAIL single_fetch_rvalid got rvalid=%b busy=%b exp 1 1", o_all[0][CT+3], o_all[0][CT+1]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_conflict();
        for (int i = 0; i < 7; i++) begin
            idle_inputs();
            if (i <= 1) begin if_req = 1'b1; if_addr = 32'h20; end
            if (i == 0) begin d_req = 1'b1; d_addr = 32'h100; d_be = 4'hF; end
            step();
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (o_all[k] !== x_all[k]) $display("FAIL conflict dut%0d cyc%0d got %h exp %h", k, cyc - 1, o_all[k], x_all[k]);
                else n_pass++;
            end
            if (i <= 1) begin
                n_total++;
                if (o_all[0][CT+7:CT+6] !== ((i == 0) ? 2'b01 : 2'b10))
                    $display("FAIL conflict_grant step%0d got %b exp %b", i, o_all[0][CT+7:CT+6], (i == 0) ? 2'b01 : 2'b10);
                else n_pass++;
            end
            if (i == 2 || i == 3) begin
                n_total++;
                if (o_all[0][CT+3:CT+2] !== ((i == 2) ? 2'b01 : 2'b10))
                    $display("FAIL conflict_rvalid step%0d got %b exp %b", i, o_all[0][CT+3:CT+2], (i == 2) ? 2'b01 : 2'b10);
                else n_pass++;
            end
        end
    endtask

    task automatic test_starvation();
        for (int i = 0; i < 14; i++) begin
            idle_inputs();
            if (i < 8) begin
                if_req = 1'b1; if_addr = 32'h40;
                d_req = 1'b1; d_addr = 32'h140; d_be = 4'hF;
            end
            step();
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (o_all[k] !== x_all[k]) $display("FAIL starvation dut%0d cyc%0d got %h exp %h", k, cyc - 1, o_all[k], x_all[k]);
                else n_pass++;
            end
            if (i < 8) begin
                n_total++;
                if (o_all[0][CT+7:CT+6] !== ((i == 4) ? 2'b10 : 2'b01))
                    $display("FAIL starvation_grant step%0d got %b exp %b", i, o_all[0][CT+7:CT+6], (i == 4) ? 2'b10 : 2'b01);
                else n_pass++;
            end
        end
    endtask

    task automatic test_flush();
        int n_irv = 0;
        for (int i = 0; i < 14; i++) begin
            idle_inputs();
            if (i <= 2) begin if_req = 1'b1; if_addr = 32'(4 * i); end
            if (i == 4) if_flush = 1'b1;
            if (i == 5) begin d_req = 1'b1; d_addr = 32'h200; d_be = 4'hF; end
            step();
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (o_all[k] !== x_all[k]) $display("FAIL flush dut%0d cyc%0d got %h exp %h", k, cyc - 1, o_all[k], x_all[k]);
                else n_pass++;
            end
            if (o_all[1][CT+3] !== 1'b0) n_irv++;
            if (i == 9) begin
                n_total++;
                if (o_all[1][CT+2] !== 1'b1) $display("FAIL flush_data_rvalid got %b exp 1", o_all[1][CT+2]);
                else n_pass++;
            end
        end
        n_total++;
        if (n_irv != 0) $display("FAIL flush_no_fetch_rvalid got %0d exp 0", n_irv);
        else n_pass++;
    endtask

    task automatic test_write();
        int n_drv [2] = '{0, 0};
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            if (i == 0) begin d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_be = 4'h3; d_wdata = 32'hDEADBEEF; end
            if (i == 1) begin d_req = 1'b1; d_addr = 32'h304; d_be = 4'hF; d_wdata = 32'h0; end
            step();
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (o_all[k] !== x_all[k]) $display("FAIL write dut%0d cyc%0d got %h exp %h", k, cyc - 1, o_all[k], x_all[k]);
                else n_pass++;
                if (o_all[k][CT+2] === 1'b1) n_drv[k]++;
            end
            if (i == 1) begin
                n_total++;
                if (o_all[0][CT+4] !== 1'b1 || o_all[0][DW +: BW] !== 4'h3 || o_all[0][DW-1:0] !== 32'hDEADBEEF)
                    $display("FAIL write_issue got we=%b be=%h wdata=%h exp 1 3 deadbeef",
                             o_all[0][CT+4], o_all[0][DW +: BW], o_all[0][DW-1:0]);
                else n_pass++;
            end
        end
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if (n_drv[k] != 1) $display("FAIL write_rvalid_count dut%0d got %0d exp 1", k, n_drv[k]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_inflight();
        int n_rv = 0;
        for (int i = 0; i < 9; i++) begin
            idle_inputs();
            rst = (i != 2);
            if (i <= 1) begin d_req = 1'b1; d_addr = 32'h400 + 32'(4 * i); d_be = 4'hF; end
            step();
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (o_all[k] !== x_all[k]) $display("FAIL reset_inflight dut%0d cyc%0d got %h exp %h", k, cyc - 1, o_all[k], x_all[k]);
                else n_pass++;
                if (i >= 3 && o_all[k][CT+3:CT+2] !== 2'b00) n_rv++;
            end
            if (i == 3) begin
                n_total++;
                if (o_all[1][CT+5:CT+4] !== 2'b00 || o_all[1][CT+1] !== 1'b0 || o_all[1][DW+BW +: AW] !== '0 || o_all[1][DW +: BW] !== '0)
                    $display("FAIL reset_inflight_clear got en_we=%b busy=%b addr=%h be=%h exp 00 0 0 0",
                             o_all[1][CT+5:CT+4], o_all[1][CT+1], o_all[1][DW+BW +: AW], o_all[1][DW +: BW]);
                else n_pass++;
            end
        end
        n_total++;
        if (n_rv != 0) $display("FAIL reset_inflight_rvalid got %0d exp 0", n_rv);
        else n_pass++;
    endtask

    task automatic test_random();
        idle_inputs();
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 49) != 0);
            if_flush = ($urandom_range(0, 9) == 0);
            if (!if_req || e_ig) begin
                if_req  = 1'($urandom_range(0, 1));
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_req || e_dg) begin
                d_req   = 1'($urandom_range(0, 1));
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_be    = 4'($urandom);
            end
            step();
            for (int k = 0; k < 2; k++) begin
                n_total++;
                if (o_all[k] !== x_all[k]) $display("FAIL random dut%0d cyc%0d got %h exp %h", k, cyc - 1, o_all[k], x_all[k]);
                else n_pass++;
            end
        end
        idle_inputs();
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_conflict();
        test_starvation();
        test_flush();
        test_write();
        test_reset_inflight();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
